// File: rtl/dsp_muladd_arbiter_if.sv
// Bundle of request, DSP-side and response signals for dsp_muladd_arbiter.
// DSPARB_LOCK_EN adds the per-requester req_lock signal.
interface dsp_muladd_arbiter_if #(
  parameter int NREQ = 4,
  parameter int A_W  = 27,
  parameter int B_W  = 18
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*A_W-1:0] req_a;
  logic [NREQ*B_W-1:0] req_b;
  logic [NREQ*48-1:0]  req_c;
`ifdef DSPARB_LOCK_EN
  logic [NREQ-1:0]     req_lock;
`endif
  logic [A_W-1:0]      dsp_a;
  logic [B_W-1:0]      dsp_b;
  logic [47:0]         dsp_c;
  logic [47:0]         dsp_p;
  logic                rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic [47:0]         rsp_p;
  logic                busy;

`ifdef DSPARB_LOCK_EN
  modport slave (
    input  req_valid, req_a, req_b, req_c, req_lock, dsp_p,
    output req_ready, dsp_a, dsp_b, dsp_c, rsp_valid, rsp_id, rsp_p, busy
  );
  modport master (
    output req_valid, req_a, req_b, req_c, req_lock, dsp_p,
    input  req_ready, dsp_a, dsp_b, dsp_c, rsp_valid, rsp_id, rsp_p, busy
  );
`else
  modport slave (
    input  req_valid, req_a, req_b, req_c, dsp_p,
    output req_ready, dsp_a, dsp_b, dsp_c, rsp_valid, rsp_id, rsp_p, busy
  );
  modport master (
    output req_valid, req_a, req_b, req_c, dsp_p,
    input  req_ready, dsp_a, dsp_b, dsp_c, rsp_valid, rsp_id, rsp_p, busy
  );
`endif
endinterface

// File: rtl/dsp_muladd_arbiter.sv
// Round-robin arbiter sharing one pipelined multiply-add DSP between NREQ
// requesters; tags each operation so results return with the issuing id.
// Optional burst lock: define DSPARB_LOCK_EN.
module dsp_muladd_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 3,
  parameter int A_W  = 27,
  parameter int B_W  = 18
) (
  input logic                  clk,
  input logic                  rst,
  dsp_muladd_arbiter_if.slave  bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef logic [IDW-1:0] id_t;

  id_t                      rr_ptr;
  id_t                      gnt_id;
  id_t                      idx;
  logic                     found;
  logic                     xfer;
  logic [NREQ-1:0]          ready;
  logic [LAT-1:0]           tag_v;
  logic [LAT-1:0][IDW-1:0]  tag_id;
  logic [A_W-1:0]           dsp_a_q;
  logic [B_W-1:0]           dsp_b_q;
  logic [47:0]              dsp_c_q;
  logic                     rsp_v_q;
  id_t                      rsp_id_q;

`ifdef DSPARB_LOCK_EN
  typedef enum logic {ARB_RR, ARB_LOCK} arb_state_t;
  arb_state_t state;
  id_t        lock_owner;
`endif

  function automatic id_t nxt(input id_t i);
    return (int'(i) == NREQ - 1) ? '0 : id_t'(i + 1'b1);
  endfunction

  // First valid requester at or after rr_ptr (or the lock owner) gets the grant
  always_comb begin
    ready  = '0;
    gnt_id = rr_ptr;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = id_t'((32'(rr_ptr) + k) % NREQ);
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = idx;
      end
    end
`ifdef DSPARB_LOCK_EN
    if (state == ARB_LOCK) begin
      gnt_id = lock_owner;
      found  = bus.req_valid[lock_owner];
    end
`endif
    if (found && !rst) ready[gnt_id] = 1'b1;
  end

  assign xfer = found && !rst;

  // Operand capture, tag shift pipeline, response register and pointer/lock state
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      dsp_a_q  <= '0;
      dsp_b_q  <= '0;
      dsp_c_q  <= '0;
      tag_v    <= '0;
      tag_id   <= '0;
      rsp_v_q  <= 1'b0;
      rsp_id_q <= '0;
`ifdef DSPARB_LOCK_EN
      state      <= ARB_RR;
      lock_owner <= '0;
`endif
    end else begin
      for (int unsigned k = 1; k < LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
      tag_v[0]  <= xfer;
      tag_id[0] <= gnt_id;
      rsp_v_q   <= tag_v[LAT-1];
      rsp_id_q  <= tag_id[LAT-1];
      if (xfer) begin
        dsp_a_q <= bus.req_a[gnt_id*A_W +: A_W];
        dsp_b_q <= bus.req_b[gnt_id*B_W +: B_W];
        dsp_c_q <= bus.req_c[gnt_id*48 +: 48];
      end
`ifdef DSPARB_LOCK_EN
      // Locking freezes rr_ptr; release resumes rotation after the owner.
      case (state)
        ARB_RR: begin
          if (xfer) begin
            if (bus.req_lock[gnt_id]) begin
              state      <= ARB_LOCK;
              lock_owner <= gnt_id;
            end else begin
              rr_ptr <= nxt(gnt_id);
            end
          end
        end
        ARB_LOCK: begin
          if (!xfer || !bus.req_lock[lock_owner]) begin
            state  <= ARB_RR;
            rr_ptr <= nxt(lock_owner);
          end
        end
        default: state <= ARB_RR;
      endcase
`else
      if (xfer) rr_ptr <= nxt(gnt_id);
`endif
    end
  end

  assign bus.req_ready = ready;
  assign bus.dsp_a     = dsp_a_q;
  assign bus.dsp_b     = dsp_b_q;
  assign bus.dsp_c     = dsp_c_q;
  assign bus.rsp_valid = rsp_v_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_p     = bus.dsp_p;
  assign bus.busy      = |tag_v;
endmodule

// File: tb/tb_dsp_muladd_arbiter.sv
// Self-checking bench for dsp_muladd_arbiter with a behavioural DSP model.
// Lock scenario is built only when DSPARB_LOCK_EN is defined.
module tb_dsp_muladd_arbiter;
  localparam int NREQ = 4;
  localparam int LAT  = 3;
  localparam int A_W  = 27;
  localparam int B_W  = 18;

  typedef struct {
    int          id;
    logic [47:0] p;
    int          cyc;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;

  dsp_muladd_arbiter_if #(.NREQ(NREQ), .A_W(A_W), .B_W(B_W)) bus ();

  dsp_muladd_arbiter #(.NREQ(NREQ), .LAT(LAT), .A_W(A_W), .B_W(B_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // DSP: P = A*B + C, LAT cycles after the operands are presented
  logic [47:0] p_pipe [LAT];
  always @(posedge clk) begin
    p_pipe[0] <= 48'(bus.dsp_a) * 48'(bus.dsp_b) + bus.dsp_c;
    for (int k = 1; k < LAT; k++) p_pipe[k] <= p_pipe[k-1];
  end
  assign bus.dsp_p = p_pipe[LAT-1];

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   m_rr   = 0;
  bit   m_locked = 1'b0;
  int   m_owner  = 0;
  rsp_t exp_q [$];
  rsp_t obs_q [$];
  int   g;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [NREQ-1:0] v);
    if (m_locked) return v[m_owner] ? m_owner : -1;
    for (int k = 0; k < NREQ; k++)
      if (v[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    return -1;
  endfunction

  function automatic void model_update(input int gi, input logic [NREQ-1:0] lk);
    if (m_locked) begin
      if (gi < 0 || !lk[gi]) begin
        m_locked = 1'b0;
        m_rr     = (m_owner + 1) % NREQ;
      end
    end else if (gi >= 0) begin
      if (lk[gi]) begin
        m_locked = 1'b1;
        m_owner  = gi;
      end else begin
        m_rr = (gi + 1) % NREQ;
      end
    end
  endfunction

  task automatic set_op(input int i, input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                        input logic [47:0] c);
    bus.req_a[i*A_W +: A_W] = a;
    bus.req_b[i*B_W +: B_W] = b;
    bus.req_c[i*48 +: 48]   = c;
  endtask

  // One clock cycle: check against the model at the falling edge, advance the model.
  task automatic tick(output int gobs);
    logic [NREQ-1:0] v, lk, exp_rdy;
    logic [A_W-1:0]  a;
    logic [B_W-1:0]  b;
    logic [47:0]     c;
    int              gi;
    bit              exp_v, exp_busy;
    rsp_t            e;
    @(negedge clk);
    v  = bus.req_valid;
    lk = '0;
`ifdef DSPARB_LOCK_EN
    lk = bus.req_lock;
`endif
    gi      = rst ? -1 : model_grant(v);
    exp_rdy = (gi >= 0) ? (NREQ'(1) << gi) : '0;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    gobs = -1;
    for (int k = NREQ - 1; k >= 0; k--) if (bus.req_ready[k]) gobs = k;
    exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_v));
    if (bus.rsp_valid) obs_q.push_back('{int'(bus.rsp_id), bus.rsp_p, cyc});
    if (exp_v) begin
      e = exp_q.pop_front();
      chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
      chk("rsp_p", 64'(bus.rsp_p), 64'(e.p));
    end
    exp_busy = 1'b0;
    foreach (exp_q[k]) if (exp_q[k].cyc > cyc) exp_busy = 1'b1;
    chk("busy", 64'(bus.busy), 64'(exp_busy));
    if (rst) begin
      exp_q.delete();
      m_rr     = 0;
      m_locked = 1'b0;
    end else begin
      if (gi >= 0) begin
        a = bus.req_a[gi*A_W +: A_W];
        b = bus.req_b[gi*B_W +: B_W];
        c = bus.req_c[gi*48 +: 48];
        exp_q.push_back('{gi, 48'(a) * 48'(b) + c, cyc + 1 + LAT});
      end
      model_update(gi, lk);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    int gd;
    bus.req_valid = '0;
    for (int k = 0; k < n; k++) tick(gd);
  endtask

  initial begin
    int t0;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_c     = '0;
`ifdef DSPARB_LOCK_EN
    bus.req_lock  = '0;
`endif
    tick(g);
    tick(g);
    chk("reset_dsp_a", 64'(bus.dsp_a), 64'd0);
    chk("reset_dsp_b", 64'(bus.dsp_b), 64'd0);
    chk("reset_dsp_c", 64'(bus.dsp_c), 64'd0);
    chk("reset_rsp_id", 64'(bus.rsp_id), 64'd0);
    rst = 1'b0;

    // Single operation from requester 2
    obs_q.delete();
    set_op(2, 27'd3, 18'd5, 48'd7);
    bus.req_valid = 4'b0100;
    t0 = cyc;
    tick(g);
    chk("single_grant", 64'(g), 64'd2);
    chk("single_dsp_a", 64'(bus.dsp_a), 64'd3);
    chk("single_dsp_c", 64'(bus.dsp_c), 64'd7);
    idle(LAT + 2);
    chk("single_rsp_cnt", 64'(obs_q.size()), 64'd1);
    chk("single_rsp_cyc", 64'(obs_q[0].cyc), 64'(t0 + 4));
    chk("single_rsp_id", 64'(obs_q[0].id), 64'd2);
    chk("single_rsp_p", 64'(obs_q[0].p), 64'd22);

    // All requesters valid from reset: strict rotation
    rst = 1'b1;
    tick(g);
    rst = 1'b0;
    obs_q.delete();
    bus.req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NREQ; i++) set_op(i, A_W'($urandom), B_W'($urandom), 48'($urandom));
      tick(g);
      chk("rr_grant", 64'(g), 64'(k % NREQ));
    end
    idle(LAT + 2);
    chk("rr_rsp_cnt", 64'(obs_q.size()), 64'd8);
    foreach (obs_q[k]) chk("rr_rsp_order", 64'(obs_q[k].id), 64'(k % NREQ));

    // Back-to-back from requester 1
    obs_q.delete();
    bus.req_valid = 4'b0010;
    for (int i = 1; i <= 6; i++) begin
      set_op(1, A_W'(i), 18'd2, 48'd0);
      tick(g);
      chk("b2b_grant", 64'(g), 64'd1);
    end
    idle(LAT + 2);
    chk("b2b_rsp_cnt", 64'(obs_q.size()), 64'd6);
    foreach (obs_q[k]) begin
      chk("b2b_rsp_p", 64'(obs_q[k].p), 64'(2 * (k + 1)));
      chk("b2b_rsp_cyc", 64'(obs_q[k].cyc), 64'(obs_q[0].cyc + k));
    end

    // Reset with three operations in flight
    bus.req_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      set_op(0, A_W'($urandom), B_W'($urandom), 48'($urandom));
      tick(g);
    end
    obs_q.delete();
    bus.req_valid = '0;
    rst = 1'b1;
    tick(g);
    rst = 1'b0;
    idle(LAT + 3);
    chk("flush_rsp_cnt", 64'(obs_q.size()), 64'd0);
    chk("flush_busy", 64'(bus.busy), 64'd0);
    bus.req_valid = '1;
    tick(g);
    chk("flush_next_grant", 64'(g), 64'd0);
    idle(LAT + 2);

`ifdef DSPARB_LOCK_EN
    // Requester 3 locks for three transfers; requester 0 waits
    rst = 1'b1;
    tick(g);
    rst = 1'b0;
    bus.req_valid = 4'b0100;
    tick(g);
    bus.req_valid = 4'b1001;
    bus.req_lock  = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) bus.req_lock = '0;
      set_op(3, A_W'($urandom), B_W'($urandom), 48'($urandom));
      tick(g);
      chk("lock_grant3", 64'(g), 64'd3);
    end
    tick(g);
    chk("lock_grant0", 64'(g), 64'd0);
    idle(LAT + 2);
`endif

    // Random mixed traffic
    for (int k = 0; k < 400; k++) begin
      bus.req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++)
        set_op(i, A_W'($urandom), B_W'($urandom), {16'($urandom), 32'($urandom)});
      tick(g);
    end
    idle(LAT + 3);
    chk("drain_outstanding", 64'(exp_q.size()), 64'd0);
    chk("drain_busy", 64'(bus.busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dsp_muladd_arbiter.md
# dsp_muladd_arbiter

Round-robin arbiter and scheduler that shares one pipelined DSP multiply-add datapath (P = A·B + C, fixed latency LAT) between NREQ requesters. It sits in front of a `DSP_muladd` instance and performs several jobs:
- registers the selected operands into the DSP;
- tracks each in-flight operation with a requester tag through a shift pipeline matched to LAT;
- returns each result with the requester ID.

The DSP pipeline cannot stall, so requests are the only backpressured side.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- LAT, 3, DSP latency from registered operands to valid `dsp_p` (1..4, equals the DSP instance latency)
- A_W, 27, operand A width
- B_W, 18, operand B width

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester grant; one-hot or zero
- req_a  in  NREQ*A_W  packed operand A; requester i at [i*A_W +: A_W]
- req_b  in  NREQ*B_W  packed operand B
- req_c  in  NREQ*48  packed addend C
- req_lock  in  NREQ  burst-lock request; present only with DSPARB_LOCK_EN
- dsp_a  out  A_W  registered operand to DSP A
- dsp_b  out  B_W  registered operand to DSP B
- dsp_c  out  48  registered addend to DSP C
- dsp_p  in  48  DSP result P
- rsp_valid  out  1  result valid, one cycle per operation
- rsp_id  out  $clog2(NREQ)  requester that issued the result
- rsp_p  out  48  result, equals `dsp_p` on valid cycles
- busy  out  1  high while any operation is in flight

## Operation
- Arbitration is combinational.
  - The candidate is the first i with req_valid[i]=1, scanning from rr_ptr upward modulo NREQ.
  - req_ready[candidate]=1; all other req_ready bits are 0.
  - req_ready never depends on req_valid of the same index beyond selection.
- Transfer: req_valid[i] & req_ready[i] in cycle t.
  - At edge t+1: dsp_a/b/c <= req_a/b/c slice i, and tag stage 0 <= {1, i}.
  - rr_ptr <= (i+1) mod NREQ.
- No transfer in a cycle: dsp_a/b/c hold their value; tag stage 0 valid <= 0.
- Tag pipeline: LAT stages of {valid, id}, advancing every cycle unconditionally.
  - rsp_valid/rsp_id are driven from the last stage.
  - rsp_p = dsp_p, passed through combinationally.
- busy = OR of all tag valid bits.
- Arithmetic is done entirely in the DSP; this block does no width conversion beyond the operand slices.
- At most one transfer per cycle; sustained throughput is 1 op/cycle across requesters.

## Timing
- Latency: transfer at cycle t -> rsp_valid=1 at cycle t+1+LAT, in issue order.
- Simultaneous requests:
  - granted strictly in rotation from rr_ptr;
  - with all NREQ valid continuously, each requester is granted once every NREQ cycles.
- A requester dropping req_valid without transfer loses nothing; the pointer does not move.
- Reset, synchronous and active-high:
  - rr_ptr=0 and all tag valid bits cleared;
  - dsp_a/b/c=0, rsp_valid=0, rsp_id=0, busy=0;
  - req_ready=0 while rst=1.
- Reset mid-operation: in-flight results are discarded. rsp_valid is 0 from the cycle after rst is sampled, even though the DSP still emits stale P.

## Configuration
- Macro DSPARB_LOCK_EN.
- Defined: the req_lock port exists.
  - A transfer by i with req_lock[i]=1 sets lock_owner=i, and rr_ptr is not advanced.
  - While locked, only i may be granted: req_ready[i]=req_valid[i], all others 0.
  - The lock releases on a transfer by i with req_lock[i]=0 (rr_ptr <= i+1), or on a cycle with req_valid[i]=0 (rr_ptr <= i+1).
  - Reset clears the lock.
- Undefined: no req_lock port and no lock state; pure round-robin.

## Test plan
- Single op, LAT=3, NREQ=4: req 2 sends A=3, B=5, C=7 at cycle 10 -> rsp_valid at cycle 14 with rsp_id=2, rsp_p=22, and busy high for cycles 11–13.
- All four valid continuously for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3, and responses return in the same order LAT+1 cycles later.
- Back-to-back: req 1 issues A=i, B=2, C=0 for i=1..6 over 6 consecutive cycles -> 6 consecutive rsp_valid cycles with rsp_p 2,4,…,12.
- Reset asserted for 1 cycle while 3 ops are in flight -> no rsp_valid afterwards, busy=0, and the next grant goes to requester 0 when all are valid.
- (DSPARB_LOCK_EN) req 3 issues with req_lock=1 for 3 transfers, then lock=0, while req 0 is valid throughout -> req 0 is granted only after the 4th req-3 transfer.
- Random mixed valid patterns checked against a reference model of P=A·B+C -> every issued op returns exactly once with the correct id and value.
